// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse digit serializer.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    GAP,
    CHAR_GAP
  } morse_state_e;

  localparam int unsigned CODE_W         = 5;
  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned SYM_GAP_UNITS  = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;

endpackage

// File: rtl/morse_digit_serializer_if.sv
// Request/status bundle between the pattern mux side and the serializer.
// With MORSE_ABORT_EN defined the bundle also carries a synchronous abort.
interface morse_digit_serializer_if;
  import morse_pkg::*;

  logic [CODE_W-1:0] code;
  logic              start;
  logic              key_out;
  logic              busy;
  logic              done;

`ifdef MORSE_ABORT_EN
  logic              abort;

  modport master (output code, start, abort, input key_out, busy, done);
  modport slave  (input code, start, abort, output key_out, busy, done);
`else
  modport master (output code, start, input key_out, busy, done);
  modport slave  (input code, start, output key_out, busy, done);
`endif

endinterface

// File: rtl/morse_unit_timer.sv
// Divides the clock into Morse time units; restart realigns the unit grid.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic unit_tick
);

  localparam int unsigned   CW   = $clog2(UNIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign unit_tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || unit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/morse_digit_serializer.sv
// Serializes a latched 5-bit Morse digit into a timed key waveform.
// Optional MORSE_ABORT_EN adds a synchronous abort to the request bundle.
module morse_digit_serializer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  morse_digit_serializer_if.slave  bus
);

  morse_state_e      state;
  morse_state_e      state_nx;
  logic [1:0]        units;
  logic [2:0]        idx;
  logic [CODE_W-1:0] code_q;
  logic [1:0]        last_unit;
  logic              tick;
  logic              restart;
  logic              accept;
  logic              leave;
  logic              done_nx;
  logic              abort_in;
  logic              abort_hit;

`ifdef MORSE_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .unit_tick (tick)
  );

  always_comb begin
    case (state)
      MARK:     last_unit = code_q[idx] ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
      GAP:      last_unit = 2'(SYM_GAP_UNITS - 1);
      CHAR_GAP: last_unit = 2'(CHAR_GAP_UNITS - 1);
      default:  last_unit = '0;
    endcase
  end

  assign leave     = tick && (units == last_unit) && (state != IDLE);
  assign abort_hit = abort_in && (state != IDLE);
  assign accept    = (state == IDLE) && bus.start && !abort_in;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:     if (accept) state_nx = MARK;
      MARK:     if (leave)  state_nx = (idx != '0) ? GAP : CHAR_GAP;
      GAP:      if (leave)  state_nx = MARK;
      CHAR_GAP: if (leave) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default:  state_nx = IDLE;
    endcase
    if (abort_hit) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
    end
  end

  // Every state entry (including abort) realigns both the unit grid and unit count.
  assign restart = accept || leave || abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bus.key_out <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      units       <= '0;
      idx         <= '0;
      code_q      <= '0;
    end else begin
      state       <= state_nx;
      bus.key_out <= (state_nx == MARK);
      bus.busy    <= (state_nx != IDLE);
      bus.done    <= done_nx;

      if (restart) begin
        units <= '0;
      end else if (tick) begin
        units <= units + 2'd1;
      end

      if (accept) begin
        code_q <= bus.code;
        idx    <= 3'(CODE_W - 1);
      end else if (abort_hit) begin
        idx <= '0;
      end else if ((state == GAP) && leave) begin
        idx <= idx - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_digit_serializer.sv
// Bench for morse_digit_serializer: two instances (UNIT_CYCLES 2 and 1) checked against a waveform model.
module tb_morse_digit_serializer;

  logic       clk;
  logic       rst_n;
  logic [4:0] code_s  [2];
  logic       start_s [2];
  logic       abort_s [2];
  logic       key_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];

  int unsigned ucyc [2] = '{2, 1};

  int total = 0;
  int bad   = 0;

  morse_digit_serializer_if b0 ();
  morse_digit_serializer_if b1 ();

  assign b0.code  = code_s[0];
  assign b0.start = start_s[0];
  assign b1.code  = code_s[1];
  assign b1.start = start_s[1];
`ifdef MORSE_ABORT_EN
  assign b0.abort = abort_s[0];
  assign b1.abort = abort_s[1];
`endif
  assign key_s[0]  = b0.key_out;
  assign busy_s[0] = b0.busy;
  assign done_s[0] = b0.done;
  assign key_s[1]  = b1.key_out;
  assign busy_s[1] = b1.busy;
  assign done_s[1] = b1.done;

  morse_digit_serializer #(.UNIT_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  morse_digit_serializer #(.UNIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  // Expected {key, busy, done} k cycles after the accepting edge.
  function automatic logic [2:0] exp_at(input logic [4:0] c, input int u, input int k);
    int pos;
    int len;
    pos = 1;
    for (int i = 4; i >= 0; i--) begin
      len = (c[i] ? 3 : 1) * u;
      if (k >= pos && k < pos + len) return 3'b110;
      pos += len;
      if (i > 0) begin
        if (k >= pos && k < pos + u) return 3'b010;
        pos += u;
      end
    end
    if (k >= pos && k < pos + 3 * u) return 3'b010;
    if (k == pos + 3 * u) return 3'b001;
    return 3'b000;
  endfunction

  logic [2:0] expv [2];
  bit         act  [2];
  int         st   [2];
  logic [4:0] cd   [2];
  int         cyc;

  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      act[d]  = 1'b0;
      expv[d] = 3'b000;
      st[d]   = 0;
      cd[d]   = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          act[d]  = 1'b0;
          expv[d] = 3'b000;
        end
      end else begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
          if (abort_s[d] && expv[d][1]) begin
            act[d] = 1'b0;
          end else if (start_s[d] && !expv[d][1] && !abort_s[d]) begin
            act[d] = 1'b1;
            st[d]  = cyc - 1;
            cd[d]  = code_s[d];
          end
          expv[d] = act[d] ? exp_at(cd[d], int'(ucyc[d]), cyc - st[d]) : 3'b000;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("d%0d_key", d),  int'(key_s[d]),  int'(expv[d][2]));
        chk($sformatf("d%0d_busy", d), int'(busy_s[d]), int'(expv[d][1]));
        chk($sformatf("d%0d_done", d), int'(done_s[d]), int'(expv[d][0]));
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge of the done cycle.
  task automatic send(input int d, input logic [4:0] c, input int exp_done,
                      input int exp_pulses, input bit disturb);
    int   n;
    int   pulses;
    logic pk;
    bit   seen;
    n = 0;
    pulses = 0;
    pk = 1'b0;
    seen = 1'b0;
    code_s[d]  = c;
    start_s[d] = 1'b1;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start_s[d] = 1'b0;
        chk($sformatf("d%0d_first_mark", d), int'(key_s[d]), 1);
      end
      if (disturb && n == 5) begin
        start_s[d] = 1'b1;
        code_s[d]  = ~c;
      end
      if (disturb && n == 6) start_s[d] = 1'b0;
      if (key_s[d] && !pk) pulses++;
      pk = key_s[d];
      if (done_s[d]) seen = 1'b1;
    end
    chk($sformatf("d%0d_done_cycle", d), n, exp_done);
    chk($sformatf("d%0d_pulses", d), pulses, exp_pulses);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      code_s[d]  = '0;
      start_s[d] = 1'b0;
      abort_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_key", d),  int'(key_s[d]),  0);
      chk($sformatf("d%0d_rst_busy", d), int'(busy_s[d]), 0);
      chk($sformatf("d%0d_rst_done", d), int'(done_s[d]), 0);
    end

    send(0, 5'b00000, 25, 5, 1'b0);
    repeat (2) @(negedge clk);
    send(0, 5'b11111, 45, 5, 1'b0);
    repeat (2) @(negedge clk);
    send(1, 5'b01111, 21, 5, 1'b1);
    // back-to-back: each next start is raised in the previous done cycle
    send(1, 5'b10000, 15, 5, 1'b0);
    send(1, 5'b00011, 17, 5, 1'b0);
    repeat (3) @(negedge clk);

    // asynchronous reset in cycle 7 of a character
    code_s[0]  = 5'b01111;
    start_s[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) start_s[0] = 1'b0;
    end
    chk("pre_rst_key", int'(key_s[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_key",  int'(key_s[0]),  0);
    chk("async_rst_busy", int'(busy_s[0]), 0);
    chk("async_rst_done", int'(done_s[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 5'b10101, 37, 5, 1'b0);
    repeat (2) @(negedge clk);

`ifdef MORSE_ABORT_EN
    code_s[0]  = 5'b11111;
    start_s[0] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start_s[0] = 1'b0;
    end
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_key",  int'(key_s[0]),  0);
    chk("abort_busy", int'(busy_s[0]), 0);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done_s[0]) seen = 1'b1;
    end
    chk("abort_no_done", int'(seen), 0);
    code_s[0]  = 5'b00000;
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    chk("abort_blocks_start_busy", int'(busy_s[0]), 0);
    chk("abort_blocks_start_key",  int'(key_s[0]),  0);
    repeat (4) @(negedge clk);
`else
    seen = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_digit_serializer.md
# morse_digit_serializer

Converts one 5-bit Morse digit pattern, as delivered by the upstream 16:1 5-bit pattern mux, into a timed on/off key waveform. Each bit becomes a dot (1 unit) or a dash (3 units), with standard Morse gaps. It is the stage directly downstream of the pattern mux and drives the transmitter's LED/buzzer output.

## Interface
- UNIT_CYCLES, default 4: clock cycles per Morse time unit; legal range ≥1. Synthesis top overrides it, e.g. 0.25 s at board clock.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- code  input  5  digit pattern from the mux; 1 = dash, 0 = dot; bit 4 is sent first.
- start  input  1  request to send `code`; sampled only while idle.
- key_out  output  1  Morse key; 1 = tone/LED on.
- busy  output  1  high from the cycle after start is accepted until the transmission completes.
- done  output  1  single-cycle pulse on completion.

## Operation
- Reset: key_out=0, busy=0, done=0, FSM=IDLE, counters cleared.
- FSM states and their exits:
  - IDLE: on start=1, latch `code`, set symbol index=4, go to MARK.
  - MARK: key_out=1 for 3 units if code[idx]=1, else 1 unit. Then go to GAP if idx>0, else to CHAR_GAP.
  - GAP: key_out=0 for 1 unit, decrement idx, go to MARK.
  - CHAR_GAP: key_out=0 for 3 units, then go to IDLE and pulse done.
- key_out and busy are registered, and derived from the next state.
- Latched code is held for the whole character. Changes on `code` while busy have no effect.
- start while busy is ignored, not queued.
- Total duration for a digit with d dashes: (12 + 2d) units, i.e. 5 marks, 4 symbol gaps, 1 char gap.
- Unit counter restarts from 0 on every state entry. Duration compare is against units×UNIT_CYCLES − 1.

## Timing
- start accepted at rising edge E0 (IDLE, start=1):
  - key_out=1 and busy=1 from cycle 1.
  - First mark occupies cycles 1..U (dot) or 1..3U (dash), where U=UNIT_CYCLES.
- done=1 and busy=0 in cycle 1+(12+2d)·U. That cycle is already IDLE.
- A start in the done cycle is accepted, giving back-to-back characters with no extra idle cycle.
- UNIT_CYCLES=1 is legal: every unit is one cycle, with no minimum-length violation.
- Reset asserted mid-character forces all outputs to reset values immediately (async) and does not generate done.

## Configuration
- MORSE_ABORT_EN defined: adds input `abort` (1 bit), sampled synchronously.
  - abort=1 in any non-IDLE state: go to IDLE next cycle with key_out=0, busy=0, done=0, counters cleared.
  - abort has priority over start in the same cycle.
- MORSE_ABORT_EN undefined: no `abort` port; a character always runs to completion or reset.

## Structure
- Shared package `morse_pkg` holds:
  - state enum (IDLE, MARK, GAP, CHAR_GAP);
  - constants CODE_W=5, DOT_UNITS=1, DASH_UNITS=3, SYM_GAP_UNITS=1, CHAR_GAP_UNITS=3.
- Sub-module `morse_unit_timer`:
  - Counts cycles up to UNIT_CYCLES−1 and emits a unit_tick.
  - Has a restart input driven on state entry.
  - Counter width is $clog2(UNIT_CYCLES+1).
- Top holds the FSM, a 2-bit unit counter, a 3-bit symbol index and the latched code.

## Test plan
- UNIT_CYCLES=2, code=00000 (digit 5), start at cycle 0:
  - key_out high in pulses of 2 cycles starting at cycle 1, separated by 2-cycle lows, 5 pulses in total.
  - done at cycle 25.
- UNIT_CYCLES=2, code=11111 (digit 0): 5 pulses of 6 cycles each; done at cycle 45.
- UNIT_CYCLES=1, code=01111 (digit 1): first pulse 1 cycle, then four 3-cycle pulses; done at cycle 21.
- Back-to-back: second start issued in the done cycle → second character's first mark begins the next cycle. A start pulse mid-character is ignored, as is a change on `code` mid-character.
- Reset asserted at cycle 7 of a transmission → key_out=0 and busy=0 asynchronously. No done pulse. A new start after release behaves normally.
- MORSE_ABORT_EN, abort=1 at cycle 10 → key_out=0 and busy=0 at cycle 11, no done. abort together with start while idle → start not accepted.
